uart_line_rx: RTL and testbench
===============================

# uart_line_rx

Receive-side line assembler for the UART path: consumes the byte stream from the UART receiver (`rxdata`/`rxdata_ok`), stores printable bytes in a line buffer, and presents a completed line when `\n` arrives. It also flags whether the line equals the board greeting "Hello FPGA". It sits between the UART receiver and the command/control logic, which reads the buffered line and then acknowledges it.

## Interface
- `MAX_LEN`, 16: line buffer depth in bytes; range 2..255.
- `ADDR_W`, 4: read address width; must equal `$clog2(MAX_LEN)`.
- `clk_uart`  in  1  UART-domain clock.
- `reset_n`  in  1  Reset: asynchronous assert, active-low.
- `rxdata`  in  8  Received byte; valid while `rxdata_ok` is high.
- `rxdata_ok`  in  1  Byte-valid level from the receiver. It may stay high for several cycles per byte.
- `rd_addr`  in  ADDR_W  Buffer read address.
- `rd_data`  out  8  Buffer byte at `rd_addr`, registered.
- `line_valid`  out  1  A completed line is held in the buffer.
- `line_len`  out  8  Number of stored bytes; meaningful while `line_valid` is high.
- `line_match`  out  1  The held line is exactly "Hello FPGA"; qualified by `line_valid`.
- `line_ack`  in  1  Single-cycle pulse that releases the held line.
- `overflow`  out  1  One-cycle pulse: the current line exceeded `MAX_LEN` and is being discarded.
- `dropped`  out  1  One-cycle pulse: a byte arrived while a line was held and was lost.

## Operation
- **Byte accept.** A byte is accepted on a rising edge of `rxdata_ok`, i.e. `rxdata_ok`=1 and `ok_q`=0.
  - `ok_q` resets to 1, so a level already high at reset release is not taken as a byte.
  - `rxdata` is sampled in the same cycle.
- **FSM states:** COLLECT (reset state), DISCARD, READY.
- **COLLECT:**
  - `\r` (0x0D): ignored, not stored.
  - `\n` (0x0A) with `len`>0: go to READY.
  - `\n` with `len`=0: ignored; empty lines are never presented.
  - Any other byte with `len`<`MAX_LEN`: write `buf[len]`, then `len`++.
  - Any other byte with `len`=`MAX_LEN`: pulse `overflow`, go to DISCARD.
- **DISCARD:**
  - All bytes are ignored until `\n`.
  - On `\n`: `len`←0, `match_q`←1, go to COLLECT. No `line_valid` is produced.
- **READY:**
  - `line_valid`=1. Buffer contents, `line_len` and `line_match` are frozen.
  - An accepted byte is lost and pulses `dropped`.
  - `line_ack`: `len`←0, `match_q`←1, go to COLLECT.
  - `line_ack` together with a byte edge in the same cycle: the ack wins and the byte is dropped (`dropped` pulses).
  - `line_ack` outside READY is ignored.
- **Match tracking:**
  - `match_q` is 1 at line start.
  - On each stored byte: `match_q` ← `match_q` & (`len` < 10) & (byte == `HELLO_STR[len]`).
  - `line_match` = `match_q` & (`len` == 10) & `line_valid`.
- **Width rules:**
  - `len` is 8 bits and saturates at `MAX_LEN`; it never wraps.
  - A `rd_addr` ≥ `line_len` returns stale buffer data, not 0.

## Timing
- **Reset values:**
  - `line_valid`=0, `line_len`=0, `line_match`=0, `overflow`=0, `dropped`=0, `rd_data`=0x00.
  - State = COLLECT, `ok_q`=1, `match_q`=1.
  - Buffer contents are not reset.
- **Latencies:**
  - A stored byte is readable on `rd_data` 2 cycles after its accept edge.
  - `line_valid` rises 1 cycle after the `\n` accept edge.
  - `line_valid` falls 1 cycle after `line_ack`.
  - `rd_data` lags `rd_addr` by 1 cycle.
  - `overflow` and `dropped` are registered 1-cycle pulses, issued in the cycle after the causing edge.
- **Back-to-back bytes:** a new rising edge is possible every 2 cycles. The minimum (1 cycle high, 1 cycle low) must be supported.
- **Reset mid-line:** the partial line is lost and the FSM returns to COLLECT immediately (asynchronously).

## Structure
- Shared package `uart_pkg` holds:
  - Constants `ASCII_CR`=8'h0D, `ASCII_LF`=8'h0A.
  - `HELLO_STR` as a 10-entry byte array "Hello FPGA", plus `HELLO_LEN`=10.
  - The FSM state enum `line_state_t` {COLLECT, DISCARD, READY}.
- The same constants serve the transmit-side greeting generator.
- One sub-module, `line_buf_ram`: a `MAX_LEN`×8 simple dual-port RAM with a synchronous write port and a registered read port.
- Edge detect, FSM, length counter and match tracking stay in the top module.

## Test plan
- Send "Hello FPGA\r\n", each byte with `rxdata_ok` held 16 cycles → `line_valid`=1, `line_len`=10, `line_match`=1; reading addresses 0..9 returns 0x48 0x65 … 0x41; `line_ack` → `line_valid`=0 next cycle.
- Send "Hello FPGB\n" and then "Hello FPGAX\n" → each gives `line_match`=0, with `line_len` 10 and 11 respectively.
- With `MAX_LEN`=16, send 17 'a' bytes then "\n", then "ok\n":
  - `overflow` pulses exactly once and no `line_valid` is produced for the long line.
  - The next line presents `line_len`=2, buffer contents "ok".
- Send "\r\n\n" → no `line_valid` and no pulses. Then hold a line in READY and send 'z' → `dropped` pulses once and the held contents are unchanged. Assert `line_ack` in the same cycle as a byte edge → `dropped` pulses and the next line starts empty.
- Byte edges at minimum spacing (1 high / 1 low) for "abc\n" → `line_len`=3 and contents "abc".
- `rxdata_ok` held high across `reset_n` release → no byte accepted. Assert `reset_n` low after "Hel" → all outputs read back at their reset values; then "Hi\n" → `line_len`=2.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART constants: control characters, board greeting, line assembler states.
package uart_pkg;

  localparam logic [7:0] ASCII_CR = 8'h0D;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  localparam int HELLO_LEN = 10;
  // "Hello FPGA"
  localparam logic [7:0] HELLO_STR [HELLO_LEN] = '{
    8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20, 8'h46, 8'h50, 8'h47, 8'h41
  };

  typedef enum logic [1:0] {COLLECT, DISCARD, READY} line_state_t;

  // Greeting byte at position idx; 0x00 beyond the end of the greeting.
  function automatic logic [7:0] hello_byte(input logic [7:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int i = 0; i < HELLO_LEN; i++) begin
      if (idx == 8'(i)) b = HELLO_STR[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/line_buf_ram.sv
// Simple dual-port line buffer: synchronous write, registered read.
module line_buf_ram #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic              clk_uart,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [7:0]        wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data
);

  logic [7:0] mem [DEPTH];

  // Write port; storage itself is never reset.
  always_ff @(posedge clk_uart) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read port; only the output register is reset.
  always_ff @(posedge clk_uart or negedge reset_n) begin
    if (!reset_n) rd_data <= 8'h00;
    else          rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/uart_line_rx.sv
// Line assembler behind the UART receiver: buffers printable bytes until LF,
// then holds the line for the command logic and flags the board greeting.
module uart_line_rx
  import uart_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  parameter int unsigned ADDR_W  = 4
) (
  input  logic              clk_uart,
  input  logic              reset_n,
  input  logic [7:0]        rxdata,
  input  logic              rxdata_ok,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [7:0]        rd_data,
  output logic              line_valid,
  output logic [7:0]        line_len,
  output logic              line_match,
  input  logic              line_ack,
  output logic              overflow,
  output logic              dropped
);

  localparam logic [7:0] MaxLen8   = 8'(MAX_LEN);
  localparam logic [7:0] HelloLen8 = 8'(HELLO_LEN);

  line_state_t state_q;
  logic        ok_q;
  logic        match_q;
  logic [7:0]  len_q;
  logic        line_valid_q;
  logic        overflow_q;
  logic        dropped_q;

  logic byte_edge;
  logic is_cr;
  logic is_lf;
  logic has_room;
  logic store_byte;

  // Byte accept is the rising edge of the receiver's valid level.
  always_comb begin
    byte_edge  = rxdata_ok & ~ok_q;
    is_cr      = (rxdata == ASCII_CR);
    is_lf      = (rxdata == ASCII_LF);
    has_room   = (len_q < MaxLen8);
    store_byte = byte_edge & (state_q == COLLECT) & ~is_cr & ~is_lf & has_room;
  end

  // Line FSM with length counter, greeting match and registered status pulses.
  always_ff @(posedge clk_uart or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= COLLECT;
      ok_q         <= 1'b1;  // a level already high at reset release is not a byte
      match_q      <= 1'b1;
      len_q        <= 8'd0;
      line_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
      dropped_q    <= 1'b0;
    end else begin
      ok_q       <= rxdata_ok;
      overflow_q <= 1'b0;
      dropped_q  <= 1'b0;
      unique case (state_q)
        COLLECT: begin
          if (byte_edge) begin
            if (is_lf) begin
              // Empty lines are swallowed.
              if (len_q != 8'd0) begin
                state_q      <= READY;
                line_valid_q <= 1'b1;
              end
            end else if (!is_cr) begin
              if (has_room) begin
                len_q   <= len_q + 8'd1;
                match_q <= match_q & (len_q < HelloLen8) & (rxdata == hello_byte(len_q));
              end else begin
                overflow_q <= 1'b1;
                state_q    <= DISCARD;
              end
            end
          end
        end
        DISCARD: begin
          if (byte_edge && is_lf) begin
            len_q   <= 8'd0;
            match_q <= 1'b1;
            state_q <= COLLECT;
          end
        end
        READY: begin
          // A byte arriving while a line is held is lost, even alongside the ack.
          if (byte_edge) dropped_q <= 1'b1;
          if (line_ack) begin
            len_q        <= 8'd0;
            match_q      <= 1'b1;
            line_valid_q <= 1'b0;
            state_q      <= COLLECT;
          end
        end
        default: state_q <= COLLECT;
      endcase
    end
  end

  // Status outputs straight from registers.
  always_comb begin
    line_valid = line_valid_q;
    line_len   = len_q;
    line_match = match_q & (len_q == HelloLen8) & line_valid_q;
    overflow   = overflow_q;
    dropped    = dropped_q;
  end

  line_buf_ram #(
    .DEPTH  (MAX_LEN),
    .ADDR_W (ADDR_W)
  ) u_line_buf (
    .clk_uart (clk_uart),
    .reset_n  (reset_n),
    .wr_en    (store_byte),
    .wr_addr  (len_q[ADDR_W-1:0]),
    .wr_data  (rxdata),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data)
  );

endmodule

// File: tb/tb_uart_line_rx.sv
// Scoreboard bench for uart_line_rx: a byte-stream reference model feeds
// expectation queues; independent monitors compare lines and status pulses.
module tb_uart_line_rx;

  localparam int MAX_LEN = 16;
  localparam int ADDR_W  = 4;
  localparam logic [7:0] LF = 8'h0A;
  localparam logic [7:0] CR = 8'h0D;

  logic              clk_uart = 1'b0;
  logic              reset_n;
  logic [7:0]        rxdata;
  logic              rxdata_ok;
  logic [ADDR_W-1:0] rd_addr = '0;
  logic [7:0]        rd_data;
  logic              line_valid;
  logic [7:0]        line_len;
  logic              line_match;
  logic              line_ack;
  logic              overflow;
  logic              dropped;
  logic              mon_ack  = 1'b0;
  logic              stim_ack = 1'b0;

  assign line_ack = mon_ack | stim_ack;

  uart_line_rx #(
    .MAX_LEN (MAX_LEN),
    .ADDR_W  (ADDR_W)
  ) dut (
    .clk_uart   (clk_uart),
    .reset_n    (reset_n),
    .rxdata     (rxdata),
    .rxdata_ok  (rxdata_ok),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .line_valid (line_valid),
    .line_len   (line_len),
    .line_match (line_match),
    .line_ack   (line_ack),
    .overflow   (overflow),
    .dropped    (dropped)
  );

  always #5 clk_uart = ~clk_uart;

  int cyc = 0;
  always @(posedge clk_uart) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  // Expectation queues (one entry per expected line / pulse).
  int         exp_len_q   [$];
  bit         exp_match_q [$];
  int         exp_cyc_q   [$];
  logic [7:0] exp_byte_q  [$];
  int         ovf_q       [$];
  int         drop_q      [$];

  // Reference model state.
  logic [7:0] cur [$];
  bit         discarding = 1'b0;
  bit         held       = 1'b0;
  bit         auto_ack   = 1'b1;
  int         exp_lines  = 0;
  int         lines_done = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic fail_note(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s @cycle %0d: bound expired or unexpected event", name, cyc);
  endtask

  function automatic bit is_hello();
    string h;
    h = "Hello FPGA";
    if (cur.size() != h.len()) return 1'b0;
    for (int i = 0; i < h.len(); i++) if (cur[i] != h[i]) return 1'b0;
    return 1'b1;
  endfunction

  // Behavioural model: 'at' is the cycle in which the DUT response should be visible.
  task automatic model_byte(input logic [7:0] b, input int at);
    if (held) begin
      drop_q.push_back(at);
    end else if (discarding) begin
      if (b == LF) begin
        discarding = 1'b0;
        cur.delete();
      end
    end else if (b == LF) begin
      if (cur.size() > 0) begin
        exp_len_q.push_back(cur.size());
        exp_match_q.push_back(is_hello());
        exp_cyc_q.push_back(at);
        foreach (cur[i]) exp_byte_q.push_back(cur[i]);
        cur.delete();
        exp_lines++;
        held = 1'b1;
      end
    end else if (b != CR) begin
      if (cur.size() < MAX_LEN) cur.push_back(b);
      else begin
        ovf_q.push_back(at);
        discarding = 1'b1;
      end
    end
  endtask

  task automatic sync_lines();
    int t;
    t = 0;
    while (lines_done != exp_lines && t < 1000) begin
      @(posedge clk_uart);
      t++;
    end
    if (lines_done != exp_lines) fail_note("line_handshake_timeout");
    held = 1'b0;
    @(posedge clk_uart); #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int hi, input int lo);
    if (held && auto_ack) sync_lines();
    @(posedge clk_uart); #1;
    rxdata    = b;
    rxdata_ok = 1'b1;
    model_byte(b, cyc + 1);
    repeat (hi) begin @(posedge clk_uart); #1; end
    rxdata_ok = 1'b0;
    rxdata    = 8'($urandom);
    repeat (lo - 1) begin @(posedge clk_uart); #1; end
  endtask

  task automatic send_str(input string s, input int hi, input int lo);
    for (int i = 0; i < s.len(); i++) send_byte(s[i], hi, lo);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_line_valid"}, line_valid, 0);
    check({tag, "_line_len"},   line_len,   0);
    check({tag, "_line_match"}, line_match, 0);
    check({tag, "_overflow"},   overflow,   0);
    check({tag, "_dropped"},    dropped,    0);
    check({tag, "_rd_data"},    rd_data,    0);
  endtask

  // Line monitor: checks each presented line against the scoreboard, then releases it.
  initial begin : line_mon
    logic [7:0] eb [256];
    int n;
    int ec;
    int t;
    bit em;
    forever begin
      @(negedge clk_uart);
      if (reset_n === 1'b1 && line_valid === 1'b1) begin
        if (exp_len_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_line @cycle %0d: got line_len %0d, expected no line", cyc,
                   line_len);
          @(posedge clk_uart); #1 mon_ack = 1'b1;
          @(posedge clk_uart); #1 mon_ack = 1'b0;
        end else begin
          n  = exp_len_q.pop_front();
          em = exp_match_q.pop_front();
          ec = exp_cyc_q.pop_front();
          for (int i = 0; i < n; i++) eb[i] = exp_byte_q.pop_front();
          check("line_rise_cycle", cyc, ec);
          check("line_len", line_len, n);
          check("line_match", line_match, em);
          for (int i = 0; i < n; i++) begin
            @(posedge clk_uart); #1 rd_addr = i[ADDR_W-1:0];
            @(posedge clk_uart);
            @(negedge clk_uart);
            check("line_byte", rd_data, eb[i]);
          end
          if (auto_ack) begin
            @(posedge clk_uart); #1 mon_ack = 1'b1;
            @(posedge clk_uart); #1 mon_ack = 1'b0;
            @(negedge clk_uart);
            check("line_valid_fall", line_valid, 0);
          end else begin
            // Held line: keep re-reading until the stimulus releases it.
            t = 0;
            while (line_valid === 1'b1 && t < 3000) begin
              for (int i = 0; i < n && line_valid === 1'b1; i++) begin
                @(posedge clk_uart); #1 rd_addr = i[ADDR_W-1:0];
                @(posedge clk_uart);
                @(negedge clk_uart);
                t++;
                if (line_valid === 1'b1) begin
                  check("held_byte", rd_data, eb[i]);
                  check("held_len", line_len, n);
                end
              end
            end
            if (t >= 3000) fail_note("held_line_release");
          end
          lines_done++;
        end
      end
    end
  end

  // Pulse monitor: every overflow/dropped pulse must match an expected event cycle.
  initial begin : pulse_mon
    int ec;
    forever begin
      @(negedge clk_uart);
      if (reset_n === 1'b1) begin
        if (overflow !== 1'b0) begin
          if (ovf_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL overflow_unexpected @cycle %0d: got pulse, expected none", cyc);
          end else begin
            ec = ovf_q.pop_front();
            check("overflow_cycle", cyc, ec);
          end
        end
        if (dropped !== 1'b0) begin
          if (drop_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL dropped_unexpected @cycle %0d: got pulse, expected none", cyc);
          end else begin
            ec = drop_q.pop_front();
            check("dropped_cycle", cyc, ec);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not complete");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
    $fatal(1);
  end

  initial begin : stim
    int t;
    int len;
    int hi;
    int lo;
    reset_n   = 1'b0;
    rxdata_ok = 1'b1;  // held high across reset release
    rxdata    = 8'h51;
    repeat (3) @(posedge clk_uart);
    @(negedge clk_uart);
    check_reset_outputs("reset");
    @(posedge clk_uart); #1 reset_n = 1'b1;
    repeat (6) begin @(posedge clk_uart); #1; end
    rxdata_ok = 1'b0;
    repeat (3) begin @(posedge clk_uart); #1; end

    send_str("Hello FPGA\r\n", 16, 4);
    send_str("Hello FPGB\n", 3, 2);
    send_str("Hello FPGAX\n", 2, 3);
    for (int i = 0; i < 17; i++) send_byte("a", 2, 2);
    send_byte(LF, 2, 2);
    send_str("ok\n", 2, 2);
    send_str("\r\n\n", 2, 2);

    // Held line, a lost byte, then ack colliding with a byte edge.
    sync_lines();
    auto_ack = 1'b0;
    send_str("hold\n", 2, 2);
    t = 0;
    while (line_valid !== 1'b1 && t < 200) begin @(posedge clk_uart); #1; t++; end
    if (line_valid !== 1'b1) fail_note("hold_line_rise");
    send_byte("z", 4, 4);
    @(posedge clk_uart); #1;
    rxdata    = "q";
    rxdata_ok = 1'b1;
    stim_ack  = 1'b1;
    model_byte("q", cyc + 1);
    held      = 1'b0;
    @(posedge clk_uart); #1 stim_ack = 1'b0;
    repeat (2) begin @(posedge clk_uart); #1; end
    rxdata_ok = 1'b0;
    repeat (3) begin @(posedge clk_uart); #1; end
    t = 0;
    while (lines_done != exp_lines && t < 1000) begin @(posedge clk_uart); #1; t++; end
    if (lines_done != exp_lines) fail_note("hold_line_release_wait");
    auto_ack = 1'b1;
    send_str("xy\n", 2, 2);

    // Minimum spacing: one cycle high, one cycle low.
    send_str("abc\n", 1, 1);

    // Randomized lines.
    for (int k = 0; k < 30; k++) begin
      len = $urandom_range(0, MAX_LEN + 2);
      hi  = $urandom_range(1, 5);
      lo  = $urandom_range(1, 5);
      if ($urandom_range(0, 9) == 0) begin
        send_str("Hello FPGA\n", hi, lo);
      end else begin
        for (int j = 0; j < len; j++) begin
          if ($urandom_range(0, 7) == 0) send_byte(CR, hi, lo);
          send_byte(8'($urandom_range(32, 126)), hi, lo);
        end
        send_byte(LF, hi, lo);
      end
    end

    // Reset in the middle of a line.
    sync_lines();
    send_str("Hel", 2, 2);
    @(posedge clk_uart); #1 reset_n = 1'b0;
    cur.delete();
    discarding = 1'b0;
    held       = 1'b0;
    @(negedge clk_uart);
    check_reset_outputs("midline_reset");
    @(posedge clk_uart); #1 reset_n = 1'b1;
    send_str("Hi\n", 2, 2);
    sync_lines();

    repeat (20) @(posedge clk_uart);
    check("lines_left", exp_len_q.size(), 0);
    check("overflow_left", ovf_q.size(), 0);
    check("dropped_left", drop_q.size(), 0);
    check("lines_presented", lines_done, exp_lines);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
